// File: rtl/audio_pkg.sv
// Shared audio constants and the stereo frame payload used by the I2S transmit path.
package audio_pkg;

    localparam int unsigned AXIS_W     = 32;
    localparam int unsigned SAMPLE_W   = 24;
    localparam int unsigned LEFT_LSB   = 0;
    localparam int unsigned RIGHT_LSB  = 8;
    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned SLOT_BITS  = 32;

    localparam int unsigned K_W    = $clog2(FRAME_BITS);
    localparam int unsigned SLOT_W = $clog2(SLOT_BITS);
    localparam int unsigned DIV_W  = 8;

    // Both samples are two's complement; the serializer treats them as raw bits.
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_frame_t;

    localparam int unsigned SHIFT_W = $bits(stereo_frame_t);

    function automatic stereo_frame_t unpack_word(input logic [AXIS_W-1:0] word);
        stereo_frame_t f;
        f.left  = word[LEFT_LSB +: SAMPLE_W];
        f.right = word[RIGHT_LSB +: SAMPLE_W];
        return f;
    endfunction

    // Data occupies slot positions 1..SAMPLE_W (one-bit I2S delay after the word-select change).
    function automatic logic is_data_slot(input logic [SLOT_W-1:0] pos);
        return (pos >= SLOT_W'(1)) && (pos <= SLOT_W'(SAMPLE_W));
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock generator: divider, SCLK toggle, falling-edge strobe and frame bit index.
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic           clk,
    input  logic           resetn,
    output logic           sclk,
    output logic           fall_c,
    output logic           frame_load_c,
    output logic [K_W-1:0] k_next_c
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
        $error("i2s_clk_gen: CLK_DIV must be within 2..255");
    end

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             sclk_d;
    logic [K_W-1:0]   k_q;
    logic [K_W-1:0]   k_d;
    logic             half_done_c;

    always_comb begin
        half_done_c  = 1'b0;
        div_d        = div_q + DIV_W'(1);
        sclk_d       = sclk;
        k_d          = k_q;
        fall_c       = 1'b0;
        frame_load_c = 1'b0;
        k_next_c     = k_q + K_W'(1);

        if (div_q == DIV_LAST) begin
            half_done_c = 1'b1;
            div_d       = '0;
            sclk_d      = ~sclk;
        end

        // A falling edge is the half-period end while SCLK is high.
        if (half_done_c && sclk) begin
            fall_c       = 1'b1;
            k_d          = k_next_c;
            frame_load_c = (k_q == K_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q <= '0;
            sclk  <= 1'b0;
            k_q   <= K_LAST;
        end else begin
            div_q <= div_d;
            sclk  <= sclk_d;
            k_q   <= k_d;
        end
    end

endmodule

// File: rtl/axis_i2s_tx.sv
// AXI-Stream to I2S transmitter with a one-word holding buffer and underrun reporting.
// Define I2S_TX_UNDERRUN_REPEAT_EN to replay the last frame on underrun instead of silence.
module axis_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned UCNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [AXIS_W-1:0] s_axis_data,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    input  logic              s_axis_last,
    output logic              i2s_sclk,
    output logic              i2s_lrclk,
    output logic              i2s_sdata,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);

    logic           fall_c;
    logic           frame_load_c;
    logic [K_W-1:0] k_next_c;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk          (clk),
        .resetn       (resetn),
        .sclk         (i2s_sclk),
        .fall_c       (fall_c),
        .frame_load_c (frame_load_c),
        .k_next_c     (k_next_c)
    );

    logic [AXIS_W-1:0]  buf_q;
    logic [AXIS_W-1:0]  buf_d;
    logic               buf_full_q;
    logic               buf_full_d;
    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] shift_d;
    logic               lrclk_d;
    logic               sdata_d;
    logic               underrun_d;
    logic [UCNT_W-1:0]  cnt_d;
    logic               accept_c;
    stereo_frame_t      fallback_c;
    stereo_frame_t      frame_c;
    logic [SLOT_W-1:0]  slot_pos_c;

    // Frame delimiting is positional; TLAST carries no meaning here.
    logic unused_last;
    assign unused_last = s_axis_last;

    assign s_axis_ready = !buf_full_q && resetn;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    stereo_frame_t last_q;
    stereo_frame_t last_d;

    always_comb begin
        last_d     = last_q;
        fallback_c = last_q;
        if (frame_load_c) begin
            last_d = frame_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign fallback_c = '0;
`endif

    // Next-state for buffer, serializer and underrun reporting.
    always_comb begin
        accept_c   = s_axis_valid && s_axis_ready;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        lrclk_d    = i2s_lrclk;
        sdata_d    = i2s_sdata;
        underrun_d = 1'b0;
        cnt_d      = underrun_cnt;
        frame_c    = buf_full_q ? unpack_word(buf_q) : fallback_c;
        slot_pos_c = k_next_c[SLOT_W-1:0];

        // A word accepted during an empty-buffer load waits for the next frame.
        if (frame_load_c && buf_full_q) begin
            buf_full_d = 1'b0;
        end else if (accept_c) begin
            buf_d      = s_axis_data;
            buf_full_d = 1'b1;
        end

        if (fall_c) begin
            lrclk_d = k_next_c[K_W-1];
            sdata_d = 1'b0;
            if (frame_load_c) begin
                shift_d = frame_c;
            end else if (is_data_slot(slot_pos_c)) begin
                sdata_d = shift_q[SHIFT_W-1];
                shift_d = {shift_q[SHIFT_W-2:0], 1'b0};
            end
        end

        if (frame_load_c && !buf_full_q) begin
            underrun_d = 1'b1;
            if (underrun_cnt != '1) begin
                cnt_d = underrun_cnt + UCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            shift_q      <= '0;
            i2s_lrclk    <= 1'b0;
            i2s_sdata    <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            shift_q      <= shift_d;
            i2s_lrclk    <= lrclk_d;
            i2s_sdata    <= sdata_d;
            underrun     <= underrun_d;
            underrun_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Directed bench for axis_i2s_tx at CLK_DIV=4; a second instance with UCNT_W=2 covers saturation.
module tb_axis_i2s_tx;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        resetn2;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        sclk;
    logic        lrclk;
    logic        sdata;
    logic        urun;
    logic [15:0] ucnt;

    logic        ready2;
    logic        sclk2;
    logic        lrclk2;
    logic        sdata2;
    logic        urun2;
    logic [1:0]  ucnt2;

    int unsigned applied = 0;
    int unsigned fails   = 0;
    int unsigned cyc     = 0;
    logic [31:0] q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axis_i2s_tx #(.CLK_DIV(4), .UCNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .s_axis_data(s_data), .s_axis_valid(s_valid),
        .s_axis_ready(s_ready), .s_axis_last(s_last), .i2s_sclk(sclk), .i2s_lrclk(lrclk),
        .i2s_sdata(sdata), .underrun(urun), .underrun_cnt(ucnt)
    );

    axis_i2s_tx #(.CLK_DIV(4), .UCNT_W(2)) dut_sat (
        .clk(clk), .resetn(resetn2), .s_axis_data(32'h0), .s_axis_valid(1'b0),
        .s_axis_ready(ready2), .s_axis_last(1'b0), .i2s_sclk(sclk2), .i2s_lrclk(lrclk2),
        .i2s_sdata(sdata2), .underrun(urun2), .underrun_cnt(ucnt2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        applied++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_bits(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] b;
        b = '0;
        for (int k = 1; k <= 24; k++) b[k] = l[24-k];
        for (int k = 33; k <= 56; k++) b[k] = r[56-k];
        return b;
    endfunction

    // Advance to the next negedge; retire a word the DUT took on the edge just passed.
    task automatic tick();
        logic acc;
        acc = s_valid && s_ready;
        @(negedge clk);
        cyc++;
        if (acc) begin
            void'(q.pop_front());
            check("ready_low_after_accept", 64'(s_ready), 64'(0));
            if (q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = q[0];
                s_last  = (q.size() == 1);
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
                s_last  = 1'b0;
            end
        end
    endtask

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        if (!s_valid) begin
            s_valid = 1'b1;
            s_data  = q[0];
            s_last  = (q.size() == 1);
        end
    endtask

    // Capture the frame whose load edge is f and compare against hand-computed samples.
    task automatic run_frame(input string tag, input int unsigned f, input logic [23:0] l,
                             input logic [23:0] r, input logic exp_u, input logic [15:0] exp_cnt,
                             input logic exp_rdy);
        logic [63:0] bits, lr;
        logic u_at, u_after, rdy_at, sclk_lo, sclk_hi;
        bits = 'x; lr = 'x; u_at = 1'bx; u_after = 1'bx; rdy_at = 1'bx; sclk_lo = 1'bx; sclk_hi = 1'bx;
        check({tag, "_on_time"}, 64'(cyc < f), 64'(1));
        while (cyc < f + 504) begin
            tick();
            if (cyc >= f && (cyc - f) % 8 == 0) begin
                bits[(cyc - f) / 8] = sdata;
                lr[(cyc - f) / 8]   = lrclk;
            end
            if (cyc == f) begin
                u_at    = urun;
                rdy_at  = s_ready;
                sclk_lo = sclk;
            end
            if (cyc == f + 1) u_after = urun;
            if (cyc == f + 4) sclk_hi = sclk;
        end
        check({tag, "_sdata"}, bits, exp_bits(l, r));
        check({tag, "_lrclk"}, lr, 64'hFFFF_FFFF_0000_0000);
        check({tag, "_underrun"}, 64'(u_at), 64'(exp_u));
        check({tag, "_underrun_pulse_end"}, 64'(u_after), 64'(0));
        check({tag, "_ready_at_load"}, 64'(rdy_at), 64'(exp_rdy));
        check({tag, "_sclk_fall"}, 64'(sclk_lo), 64'(0));
        check({tag, "_sclk_rise"}, 64'(sclk_hi), 64'(1));
        check({tag, "_ucnt"}, 64'(ucnt), 64'(exp_cnt));
    endtask

    initial begin
        int unsigned base;
        logic [1:0] exp_sat;
        resetn  = 1'b0;
        resetn2 = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_sclk", 64'(sclk), 64'(0));
        check("rst_lrclk", 64'(lrclk), 64'(0));
        check("rst_sdata", 64'(sdata), 64'(0));
        check("rst_underrun", 64'(urun), 64'(0));
        check("rst_ucnt", 64'(ucnt), 64'(0));
        check("rst_ready", 64'(s_ready), 64'(0));

        // Idle after reset: SCLK rises at edge 4, first load (underrun) at edge 8.
        resetn = 1'b1;
        cyc    = 0;
        repeat (3) tick();
        check("idle_sclk_before_rise", 64'(sclk), 64'(0));
        tick();
        check("idle_sclk_rise", 64'(sclk), 64'(1));
        run_frame("idle", 8, 24'h0, 24'h0, 1'b1, 16'd1, 1'b1);

        push(32'h1234_5678);
        run_frame("single", 520, 24'h345678, 24'h123456, 1'b0, 16'd1, 1'b1);

        run_frame("underrun", 1032, REPEAT ? 24'h345678 : 24'h0, REPEAT ? 24'h123456 : 24'h0,
                  1'b1, 16'd2, 1'b1);

        push(32'h1111_1100);
        push(32'h2222_2200);
        push(32'h3333_3300);
        run_frame("b2b_1", 1544, 24'h111100, 24'h111111, 1'b0, 16'd2, 1'b1);
        run_frame("b2b_2", 2056, 24'h222200, 24'h222222, 1'b0, 16'd2, 1'b1);
        run_frame("b2b_3", 2568, 24'h333300, 24'h333333, 1'b0, 16'd2, 1'b1);

        // Word accepted on the same edge as an empty-buffer load: held for the next frame.
        while (cyc < 3079) tick();
        push(32'hAABB_CCDD);
        run_frame("collide", 3080, REPEAT ? 24'h333300 : 24'h0, REPEAT ? 24'h333333 : 24'h0,
                  1'b1, 16'd3, 1'b0);
        run_frame("collide_next", 3592, 24'hBBCCDD, 24'hAABBCC, 1'b0, 16'd3, 1'b1);

        // Reset at k=40 of a frame carrying 0x55667788 with 0x0F0E0D0C buffered.
        push(32'h5566_7788);
        while (cyc < 4104) tick();
        push(32'h0F0E_0D0C);
        while (cyc < 4424) tick();
        check("pre_rst_lrclk", 64'(lrclk), 64'(1));
        check("pre_rst_sdata", 64'(sdata), 64'(1));
        check("pre_rst_ready", 64'(s_ready), 64'(0));
        resetn = 1'b0;
        tick();
        check("mid_rst_sclk", 64'(sclk), 64'(0));
        check("mid_rst_lrclk", 64'(lrclk), 64'(0));
        check("mid_rst_sdata", 64'(sdata), 64'(0));
        check("mid_rst_underrun", 64'(urun), 64'(0));
        check("mid_rst_ucnt", 64'(ucnt), 64'(0));
        check("mid_rst_ready", 64'(s_ready), 64'(0));
        tick();
        tick();
        resetn = 1'b1;
        cyc    = 0;
        tick();
        check("post_rst_ready", 64'(s_ready), 64'(1));
        run_frame("post_rst", 8, 24'h0, 24'h0, 1'b1, 16'd1, 1'b1);

        // Saturation on the 2-bit counter instance.
        check("sat_rst_ucnt", 64'(ucnt2), 64'(0));
        resetn2 = 1'b1;
        base    = cyc;
        for (int n = 0; n < 5; n++) begin
            while (cyc < base + 8 + 512 * n) tick();
            exp_sat = (n < 3) ? 2'(n + 1) : 2'd3;
            check($sformatf("sat_underrun_%0d", n), 64'(urun2), 64'(1));
            check($sformatf("sat_ucnt_%0d", n), 64'(ucnt2), 64'(exp_sat));
            check($sformatf("sat_sdata_%0d", n), 64'(sdata2), 64'(0));
            check($sformatf("sat_lrclk_%0d", n), 64'(lrclk2), 64'(0));
            check($sformatf("sat_sclk_%0d", n), 64'(sclk2), 64'(0));
            check($sformatf("sat_ready_%0d", n), 64'(ready2), 64'(1));
            tick();
            check($sformatf("sat_pulse_end_%0d", n), 64'(urun2), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

endmodule
